// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the streaming 2D convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_EMIT,
    ST_DONE
  } conv_state_t;

  // Working widths for the shift/saturate helper; wide enough for any practical ACC_W.
  localparam int SAT_W = 128;
  localparam int RES_W = 64;

  function automatic int out_dim(input int size, input int size_ker, input int stride);
    return (stride < 1) ? 1 : ((size - size_ker) / stride + 1);
  endfunction

  function automatic int acc_width(input int width_bit, input int size_ker);
    return 2 * width_bit + $clog2(size_ker * size_ker);
  endfunction

  function automatic logic signed [RES_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                        input int frac,
                                                        input int width_bit);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    logic signed [SAT_W-1:0] res;
    shifted = acc >>> frac;
    max_v   = (SAT_W'(1) <<< (width_bit - 1)) - SAT_W'(1);
    min_v   = ~max_v;
    if (shifted > max_v)      res = max_v;
    else if (shifted < min_v) res = min_v;
    else                      res = shifted;
    return RES_W'(res);
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Single shared multiply-accumulate with clear/enable, followed by the
// arithmetic-shift and saturate stage that forms the output sample.
module conv_mac_sat
  import conv_pkg::*;
#(
  parameter int WIDTH_BIT = 16,
  parameter int ACC_W     = 36,
  parameter int FRAC      = 0
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [WIDTH_BIT-1:0] i_pix,
  input  logic signed [WIDTH_BIT-1:0] i_coef,
  output logic signed [WIDTH_BIT-1:0] o_data
);

  logic signed [2*WIDTH_BIT-1:0] w_prod;
  logic signed [ACC_W-1:0]       w_prod_ext;
  logic signed [ACC_W-1:0]       r_acc;
  logic signed [SAT_W-1:0]       w_acc_ext;
  logic signed [RES_W-1:0]       w_sat;

  assign w_prod     = i_pix * i_coef;
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // Accumulator is held during EMIT, so the output stays stable under backpressure.
  assign w_acc_ext = SAT_W'(r_acc);
  assign w_sat     = sat_shift(w_acc_ext, FRAC, WIDTH_BIT);
  assign o_data    = WIDTH_BIT'(w_sat);

endmodule

// File: rtl/conv2_stream.sv
// Streaming valid-mode 2D correlation: captures image and kernel on start, walks
// output windows row-major through one shared MAC and emits each result on a valid/ready port.
module conv2_stream
  import conv_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16,
  parameter int STRIDE    = 1,
  parameter int FRAC      = 0
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
  input  logic signed [WIDTH_BIT-1:0] inpKernel  [SIZEKer][SIZEKer],
  output logic                        busy,
  output logic                        done,
  output logic                        outValid,
  input  logic                        outReady,
  output logic signed [WIDTH_BIT-1:0] outData,
  output logic [$clog2(out_dim(SIZE, SIZEKer, STRIDE)):0] outRow,
  output logic [$clog2(out_dim(SIZE, SIZEKer, STRIDE)):0] outCol,
  output logic                        outLast
);

  localparam int OUT   = out_dim(SIZE, SIZEKer, STRIDE);
  localparam int ACC_W = acc_width(WIDTH_BIT, SIZEKer);
  localparam int RC_W  = $clog2(OUT) + 1;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int KI_W  = (SIZEKer > 1) ? $clog2(SIZEKer) : 1;

  localparam logic [KI_W-1:0] KI_LAST = KI_W'(SIZEKer - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(OUT - 1);

  if (STRIDE < 1) begin : g_bad_stride
    $error("conv2_stream: STRIDE must be at least 1");
  end
  if (SIZEKer > SIZE) begin : g_bad_ker
    $error("conv2_stream: SIZEKer must not exceed SIZE");
  end
  if (FRAC >= WIDTH_BIT) begin : g_bad_frac
    $error("conv2_stream: FRAC must be below WIDTH_BIT");
  end

  conv_state_t r_state;
  conv_state_t w_state_nxt;

  logic signed [WIDTH_BIT-1:0] r_img [SIZE][SIZE];
  logic signed [WIDTH_BIT-1:0] r_ker [SIZEKer][SIZEKer];

  logic [KI_W-1:0]  r_ki;
  logic [KI_W-1:0]  r_kj;
  logic [RC_W-1:0]  r_row;
  logic [RC_W-1:0]  r_col;
  logic [IDX_W-1:0] w_ir;
  logic [IDX_W-1:0] w_ic;

  logic w_accept;
  logic w_fire;
  logic w_last_term;
  logic w_last_out;
  logic w_clr;
  logic w_en;
  logic signed [WIDTH_BIT-1:0] w_pix;
  logic signed [WIDTH_BIT-1:0] w_coef;

  assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_fire      = (r_state == ST_EMIT) && outReady;
  assign w_last_term = (r_ki == KI_LAST) && (r_kj == KI_LAST);
  assign w_last_out  = (r_row == RC_LAST) && (r_col == RC_LAST);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:          w_state_nxt = ST_MAC;
      ST_MAC:           if (w_last_term) w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (outReady) w_state_nxt = w_last_out ? ST_DONE : ST_MAC;
      end
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Image and kernel are plain data: loaded only on an accepted start, never cleared.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_img <= inpMatrixI;
      r_ker <= inpKernel;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_ki  <= '0;
      r_kj  <= '0;
      r_row <= '0;
      r_col <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_ki  <= '0;
          r_kj  <= '0;
          r_row <= '0;
          r_col <= '0;
        end
        ST_MAC: begin
          if (r_kj == KI_LAST) begin
            r_kj <= '0;
            r_ki <= (r_ki == KI_LAST) ? '0 : r_ki + KI_W'(1);
          end else begin
            r_kj <= r_kj + KI_W'(1);
          end
        end
        ST_EMIT: begin
          if (outReady && !w_last_out) begin
            if (r_col == RC_LAST) begin
              r_col <= '0;
              r_row <= r_row + RC_W'(1);
            end else begin
              r_col <= r_col + RC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_ir   = IDX_W'(int'(r_row) * STRIDE + int'(r_ki));
  assign w_ic   = IDX_W'(int'(r_col) * STRIDE + int'(r_kj));
  assign w_pix  = r_img[w_ir][w_ic];
  assign w_coef = r_ker[r_ki][r_kj];
  assign w_clr  = (r_state == ST_LOAD) || w_fire;
  assign w_en   = (r_state == ST_MAC);

  conv_mac_sat #(
    .WIDTH_BIT(WIDTH_BIT),
    .ACC_W    (ACC_W),
    .FRAC     (FRAC)
  ) u_mac (
    .clock  (clock),
    .nreset (nreset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_pix  (w_pix),
    .i_coef (w_coef),
    .o_data (outData)
  );

  assign busy     = (r_state == ST_LOAD) || (r_state == ST_MAC) || (r_state == ST_EMIT);
  assign done     = (r_state == ST_DONE);
  assign outValid = (r_state == ST_EMIT);
  assign outLast  = outValid && w_last_out;
  assign outRow   = r_row;
  assign outCol   = r_col;

endmodule
